// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: IF-stage FSM encoding, instruction size,
// NOP word and a PC alignment helper.
package mips_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux for the IF stage: exception > EX branch > ID jump.
// The exception leg exists only when PC_EXCEPTION_EN is defined.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = 32'h0000_0080
) (
`ifdef PC_EXCEPTION_EN
    input  logic        exc_req,
`endif
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    output logic        redir,
    output logic [31:0] redir_pc
);

    logic        exc_sel;
    logic [31:0] raw_pc;

`ifdef PC_EXCEPTION_EN
    assign exc_sel = exc_req;
`else
    assign exc_sel = 1'b0;
`endif

    // EX is older than ID, so a branch wins over a jump in the same cycle.
    always_comb begin
        raw_pc = jmp_target;
        if (exc_sel) begin
            raw_pc = EXC_VEC;
        end else if (br_taken) begin
            raw_pc = br_target;
        end
    end

    assign redir    = exc_sel | br_taken | jmp_taken;
    assign redir_pc = align_pc(raw_pc);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// MIPS IF stage: PC sequencing, variable-latency imem req/ack and the IF/ID register.
// Optional exception redirect and EPC capture are enabled by defining PC_EXCEPTION_EN.
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef PC_EXCEPTION_EN
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    output logic [31:0] epc,
`endif
    output logic [1:0]  dbg_state
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] seq_pc;

    pc_next_sel #(.EXC_VEC(EXC_VEC)) u_next_sel (
`ifdef PC_EXCEPTION_EN
        .exc_req    (exc_req),
`endif
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .redir      (redir),
        .redir_pc   (redir_pc)
    );

    assign seq_pc = align_pc(pc_q + INSTR_BYTES);

    // A word sitting in IF/ID is consumed by ID on any unstalled cycle, so
    // if_valid drops unless a fresh word lands or stall holds the register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redir) begin
                    pc_d       = redir_pc;
                    if_valid_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redir) begin
                        if_valid_d = 1'b0;
                        pc_d       = redir_pc;
                        pend_d     = 1'b0;
                    end else if (pend_q) begin
                        if_valid_d = 1'b0;
                        pc_d       = pend_pc_q;
                        pend_d     = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if (stall) begin
                            state_d = ST_HOLD;
                        end else begin
                            pc_d = seq_pc;
                        end
                    end
                end else if (redir) begin
                    // imem_addr must stay put until ack; remember where to go next.
                    pend_d     = 1'b1;
                    pend_pc_d  = redir_pc;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    pc_d       = redir_pc;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    pc_d       = seq_pc;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_WORD;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef PC_EXCEPTION_EN
    logic [31:0] epc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q <= '0;
        end else if (exc_req) begin
            epc_q <= exc_pc;
        end
    end

    assign epc = epc_q;
`endif

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign dbg_state = state_q;

endmodule
